dz_scan_driver: RTL and testbench

- Parametrised 8x8 bicolour dot-matrix driver: latches a decimal digit (0-9) plus colour, row-scans the matrix continuously and drives red/green column buses.
- Generalises the single-digit red-only display: full digit font, per-frame tear-free updates, red/green/yellow selection, blink mode, programmable scan rate and output polarity.
- Sits between the counter/control logic (digit producer) and the board dot-matrix pins.

---
 rtl/dz_scan_driver.sv | 197 +++++++++++++++++++
 tb/tb_dz_scan_driver.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/dz_scan_driver.sv
// dz_scan_driver
// Bicolour 8x8 dot-matrix driver. It latches a decimal digit and a colour,
// scans the matrix one row at a time, and drives the red and green column
// buses for the row that is currently selected.
// A new digit or colour is taken only at a frame boundary, so a frame is
// never drawn with two different digits.
//
// Ports
//   clk         system clock
//   rst_n       asynchronous active-low reset
//   num_valid   one-cycle strobe; num and color are sampled while it is high
//   num[3:0]    digit 0-9; values 10-15 show a blank glyph
//   color[1:0]  00 off, 01 red, 10 green, 11 yellow
//   blink_en    level input; blinks the lit pixels
//   row[7:0]    row select, bit i = row i
//   colr[7:0]   red column data, bit 7 = leftmost column
//   colg[7:0]   green column data
//   frame_start one-cycle pulse when row 0 becomes active
module dz_scan_driver #(
  parameter int SCAN_DIV       = 1000,
  parameter int BLINK_FRAMES   = 64,
  parameter bit ROW_ACTIVE_LOW = 1'b1,
  parameter bit COL_ACTIVE_LOW = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       num_valid,
  input  logic [3:0] num,
  input  logic [1:0] color,
  input  logic       blink_en,
  output logic [7:0] row,
  output logic [7:0] colr,
  output logic [7:0] colg,
  output logic       frame_start
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(BLINK_FRAMES - 1);
  localparam logic [7:0] ROW_IDLE = ROW_ACTIVE_LOW ? 8'hFF : 8'h00;
  localparam logic [7:0] COL_IDLE = COL_ACTIVE_LOW ? 8'hFF : 8'h00;

  // 8x8 digit font. Each row is one byte, row 0 is the top byte and bit 7 is
  // the leftmost column.
  function automatic logic [7:0] font_row(input logic [3:0] digit,
                                          input logic [2:0] r);
    logic [63:0] g;
    logic [63:0] sh;
    case (digit)
      4'd0:    g = 64'h003C666E7666663C;
      4'd1:    g = 64'h001838181818187E;
      4'd2:    g = 64'h003C66060C30607E;
      4'd3:    g = 64'h003C66061C06663C;
      4'd4:    g = 64'h000C1C2C4C7E0C0C;
      4'd5:    g = 64'h007E607C0606663C;
      4'd6:    g = 64'h003C607C6666663C;
      4'd7:    g = 64'h007E060C18303030;
      4'd8:    g = 64'h003C66663C66663C;
      4'd9:    g = 64'h003C66663E060C38;
      default: g = 64'h0;
    endcase
    sh = g << {r, 3'b000};
    return sh[63:56];
  endfunction

  function automatic logic [7:0] col_pol(input logic [7:0] lit);
    return COL_ACTIVE_LOW ? ~lit : lit;
  endfunction

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [2:0]       row_idx_q, row_idx_d;
  logic [3:0]       act_num_q, act_num_d;
  logic [1:0]       act_col_q, act_col_d;
  logic [3:0]       pend_num_q, pend_num_d;
  logic [1:0]       pend_col_q, pend_col_d;
  logic             pend_vld_q, pend_vld_d;
  logic [FRM_W-1:0] frm_cnt_q, frm_cnt_d;
  logic             blink_on_q, blink_on_d;
  logic [7:0]       row_q, row_d;
  logic [7:0]       colr_q, colr_d;
  logic [7:0]       colg_q, colg_d;
  logic             frame_start_q, frame_start_d;

  logic       tick;
  logic       boundary;
  logic [7:0] glyph;
  logic [7:0] lit_r;
  logic [7:0] lit_g;
  logic [7:0] onehot;

  always_comb begin
    tick     = (div_cnt_q == DIV_LAST);
    boundary = tick && (row_idx_q == 3'd7);

    div_cnt_d = tick ? '0 : div_cnt_q + DIV_W'(1);
    row_idx_d = tick ? row_idx_q + 3'd1 : row_idx_q;

    // A strobe on the boundary cycle itself goes straight to the active
    // digit; on any other cycle it waits in the pending register.
    act_num_d  = act_num_q;
    act_col_d  = act_col_q;
    pend_num_d = pend_num_q;
    pend_col_d = pend_col_q;
    pend_vld_d = pend_vld_q;
    if (boundary) begin
      if (num_valid) begin
        act_num_d  = num;
        act_col_d  = color;
        pend_vld_d = 1'b0;
      end else if (pend_vld_q) begin
        act_num_d  = pend_num_q;
        act_col_d  = pend_col_q;
        pend_vld_d = 1'b0;
      end
    end else if (num_valid) begin
      pend_num_d = num;
      pend_col_d = color;
      pend_vld_d = 1'b1;
    end

    frm_cnt_d  = frm_cnt_q;
    blink_on_d = blink_on_q;
    if (!blink_en) begin
      frm_cnt_d  = '0;
      blink_on_d = 1'b1;
    end else if (boundary) begin
      if (frm_cnt_q == FRM_LAST) begin
        frm_cnt_d  = '0;
        blink_on_d = ~blink_on_q;
      end else begin
        frm_cnt_d = frm_cnt_q + FRM_W'(1);
      end
    end

    // Outputs are built from the next-state values so that the row, its
    // pixels and the blink phase all change together on the tick edge.
    glyph  = font_row(act_num_d, row_idx_d);
    lit_r  = act_col_d[0] ? glyph : 8'h00;
    lit_g  = act_col_d[1] ? glyph : 8'h00;
    if (blink_en && !blink_on_d) begin
      lit_r = 8'h00;
      lit_g = 8'h00;
    end
    onehot = 8'h01 << row_idx_d;

    row_d  = row_q;
    colr_d = colr_q;
    colg_d = colg_q;
    if (tick) begin
      row_d  = ROW_ACTIVE_LOW ? ~onehot : onehot;
      colr_d = col_pol(lit_r);
      colg_d = col_pol(lit_g);
    end
    frame_start_d = boundary;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_q     <= '0;
      row_idx_q     <= 3'd7;
      act_num_q     <= 4'd0;
      act_col_q     <= 2'b00;
      pend_vld_q    <= 1'b0;
      frm_cnt_q     <= '0;
      blink_on_q    <= 1'b1;
      row_q         <= ROW_IDLE;
      colr_q        <= COL_IDLE;
      colg_q        <= COL_IDLE;
      frame_start_q <= 1'b0;
    end else begin
      div_cnt_q     <= div_cnt_d;
      row_idx_q     <= row_idx_d;
      act_num_q     <= act_num_d;
      act_col_q     <= act_col_d;
      pend_vld_q    <= pend_vld_d;
      frm_cnt_q     <= frm_cnt_d;
      blink_on_q    <= blink_on_d;
      row_q         <= row_d;
      colr_q        <= colr_d;
      colg_q        <= colg_d;
      frame_start_q <= frame_start_d;
    end
  end

  // Pending payload is only meaningful while pend_vld_q is set.
  always_ff @(posedge clk) begin
    pend_num_q <= pend_num_d;
    pend_col_q <= pend_col_d;
  end

  assign row         = row_q;
  assign colr        = colr_q;
  assign colg        = colg_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_dz_scan_driver.sv
module tb_dz_scan_driver;

  localparam int SD    = 4;
  localparam int FRAME = 8 * SD;
  localparam int LIMIT = 5000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       num_valid = 1'b0;
  logic [3:0] num = 4'd0;
  logic [1:0] color = 2'b00;
  logic       blink_en = 1'b0;
  logic [7:0] row;
  logic [7:0] colr;
  logic [7:0] colg;
  logic       frame_start;

  int n_total = 0;
  int n_bad   = 0;
  int ecnt;

  typedef struct packed {
    logic [3:0] num;
    logic [1:0] col;
    logic [7:0] lit;
  } desc_t;

  desc_t sb_q[$];
  desc_t cur;
  logic  have_cur = 1'b0;

  logic [7:0] font1 [8] = '{8'h00, 8'h18, 8'h38, 8'h18, 8'h18, 8'h18, 8'h18, 8'h7E};
  logic [7:0] font5 [8] = '{8'h00, 8'h7E, 8'h60, 8'h7C, 8'h06, 8'h06, 8'h66, 8'h3C};

  dz_scan_driver #(
    .SCAN_DIV(SD),
    .BLINK_FRAMES(2),
    .ROW_ACTIVE_LOW(1'b1),
    .COL_ACTIVE_LOW(1'b0)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .num_valid(num_valid),
    .num(num),
    .color(color),
    .blink_en(blink_en),
    .row(row),
    .colr(colr),
    .colg(colg),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] exp_glyph(input logic [3:0] d, input int r);
    if (d == 4'd1) return font1[r];
    if (d == 4'd5) return font5[r];
    return 8'h00;
  endfunction

  // Posedges seen since the last reset release.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) ecnt <= 0;
    else        ecnt <= ecnt + 1;
  end

  // Monitor: row 0 of frame f appears after edge SD + f*FRAME; a frame
  // descriptor is popped there and every cycle of the frame is compared.
  always @(negedge clk) begin
    int ph;
    int r;
    logic [7:0] er;
    logic [7:0] eg;
    if (!rst_n) begin
      have_cur = 1'b0;
      chk("rst_row", row, 8'hFF);
      chk("rst_colr", colr, 8'h00);
      chk("rst_colg", colg, 8'h00);
      chk("rst_fs", {7'd0, frame_start}, 8'h00);
    end else if (ecnt < SD) begin
      chk("init_row", row, 8'hFF);
      chk("init_colr", colr, 8'h00);
      chk("init_colg", colg, 8'h00);
      chk("init_fs", {7'd0, frame_start}, 8'h00);
    end else begin
      ph = (ecnt - SD) % FRAME;
      if (ph == 0) begin
        chk("sb_underflow", 8'(sb_q.size() == 0), 8'h00);
        if (sb_q.size() != 0) begin
          cur = sb_q.pop_front();
          have_cur = 1'b1;
        end else begin
          have_cur = 1'b0;
        end
      end
      if (have_cur) begin
        r  = ph / SD;
        er = (cur.col[0] && cur.lit[r]) ? exp_glyph(cur.num, r) : 8'h00;
        eg = (cur.col[1] && cur.lit[r]) ? exp_glyph(cur.num, r) : 8'h00;
        chk("row", row, ~(8'h01 << r));
        chk("colr", colr, er);
        chk("colg", colg, eg);
        chk("fs", {7'd0, frame_start}, 8'((ph == 0) ? 1 : 0));
      end
    end
  end

  function automatic int fb(input int f);
    return SD + f * FRAME;
  endfunction

  task automatic goto_edge(input int e);
    int guard = 0;
    while (ecnt < e && guard < LIMIT) begin
      @(posedge clk);
      #1;
      guard++;
    end
    chk("goto_timeout", 8'((guard >= LIMIT) ? 1 : 0), 8'h00);
  endtask

  // num_valid is high during the cycle that ends with edge e.
  task automatic strobe_at(input int e, input logic [3:0] n, input logic [1:0] c);
    goto_edge(e - 1);
    num_valid = 1'b1;
    num       = n;
    color     = c;
    goto_edge(e);
    num_valid = 1'b0;
  endtask

  task automatic push(input logic [3:0] n, input logic [1:0] c, input logic [7:0] lit);
    desc_t d;
    d.num = n;
    d.col = c;
    d.lit = lit;
    sb_q.push_back(d);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    push(4'd0, 2'b00, 8'hFF);                 // frame 0: blank after reset
    push(4'd5, 2'b01, 8'hFF);                 // frame 1: red 5 via boundary strobe
    strobe_at(fb(1), 4'd5, 2'b01);

    push(4'd1, 2'b10, 8'hFF);                 // frame 2: last strobe wins
    strobe_at(fb(1) + 3 * SD + 1, 4'd1, 2'b11);
    strobe_at(fb(1) + 5 * SD + 1, 4'd1, 2'b10);

    push(4'd12, 2'b11, 8'hFF);                // frame 3: out-of-range digit
    strobe_at(fb(2) + 2 * SD + 1, 4'd12, 2'b11);

    push(4'd1, 2'b11, 8'hFF);                 // frame 4: yellow 1
    strobe_at(fb(3) + 1 * SD + 1, 4'd1, 2'b11);

    goto_edge(fb(4));
    blink_en = 1'b1;
    push(4'd1, 2'b11, 8'hFF);                 // frame 5: still lit
    push(4'd1, 2'b11, 8'h00);                 // frame 6: off
    push(4'd1, 2'b11, 8'hF0);                 // frame 7: off, lit again from row 4
    push(4'd1, 2'b11, 8'hFF);                 // frame 8
    push(4'd1, 2'b11, 8'hFF);                 // frame 9
    goto_edge(fb(7) + 3 * SD + 1);
    blink_en = 1'b0;

    goto_edge(fb(9) + 4 * SD + 1);
    rst_n = 1'b0;
    #1;
    chk("async_row", row, 8'hFF);
    chk("async_colr", colr, 8'h00);
    chk("async_colg", colg, 8'h00);
    chk("async_fs", {7'd0, frame_start}, 8'h00);
    chk("sb_left", 8'(sb_q.size()), 8'h00);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    push(4'd0, 2'b00, 8'hFF);                 // blank until a new strobe
    push(4'd5, 2'b10, 8'hFF);
    strobe_at(fb(0) + 2 * SD + 1, 4'd5, 2'b10);
    goto_edge(fb(2) - 1);
    @(negedge clk);
    #1;
    chk("sb_final", 8'(sb_q.size()), 8'h00);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
